// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bus of fifo_wr_arbiter. The arbiter connects through
// the master modport; the requesters and the FIFO sit on the slave modport.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4
) ();
  localparam int ID_W = $clog2(REQ_NUM);

  logic [REQ_NUM*DATA_WIDTH-1:0] s_data;
  logic [REQ_NUM-1:0]            s_valid;
  logic [REQ_NUM-1:0]            s_ready;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic [ID_W-1:0]               gnt_id;
  logic                          busy;

  modport master (
    input  s_data, s_valid, fifo_full,
    output s_ready, fifo_wr_data, fifo_wr_en, gnt_id, busy
  );

  modport slave (
    output s_data, s_valid, fifo_full,
    input  s_ready, fifo_wr_data, fifo_wr_en, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging REQ_NUM requesters into one FIFO write port.
// Optional per-requester beat statistics are enabled by defining FIFO_WR_ARBITER_STAT_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       s_rst_n,
  fifo_wr_arbiter_if.master          bus
`ifdef FIFO_WR_ARBITER_STAT_EN
  ,
  input  logic [$clog2(REQ_NUM)-1:0] stat_sel,
  output logic [15:0]                stat_cnt
`endif
);
  localparam int ID_W  = $clog2(REQ_NUM);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]       last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]       pick_s;
  logic [REQ_NUM-1:0]    s_ready_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    pick_s = last_gnt_q;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = ID_W'((int'(last_gnt_q) + k) % REQ_NUM);
      if (!found && bus.s_valid[cand]) begin
        found  = 1'b1;
        pick_s = cand;
      end else begin
        found  = found;
      end
    end
  end

  // Grant-side handshake; gated by reset so nothing transfers while held in reset
  always_comb begin
    s_ready_s = '0;
    wr_en_s   = 1'b0;
    wr_data_s = '0;
    if (s_rst_n && (state_q == GRANT)) begin
      s_ready_s[gnt_id_q] = ~bus.fifo_full;
      wr_en_s             = bus.s_valid[gnt_id_q] & ~bus.fifo_full;
      wr_data_s           = bus.s_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FSM next-state: a full stall holds everything, a dropped valid ends the grant early
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.s_valid) begin
          gnt_id_d   = pick_s;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.s_valid[gnt_id_q]) begin
          last_gnt_d = gnt_id_q;
          state_d    = IDLE;
        end else if (wr_en_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
            last_gnt_d = gnt_id_q;
            state_d    = IDLE;
          end else begin
            state_d = GRANT;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM registers; last_gnt resets to the top index so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      last_gnt_q <= ID_W'(REQ_NUM - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.s_ready      = s_ready_s;
  assign bus.fifo_wr_en   = wr_en_s;
  assign bus.fifo_wr_data = wr_data_s;
  assign bus.gnt_id       = gnt_id_q;
  assign bus.busy         = (state_q == GRANT);

`ifdef FIFO_WR_ARBITER_STAT_EN
  logic [15:0] stat_q [REQ_NUM];
  logic [15:0] stat_d [REQ_NUM];
  logic [15:0] stat_cnt_q, stat_cnt_d;

  // Saturating per-requester beat counters and the selected-counter readout
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      stat_d[i] = stat_q[i];
      if (wr_en_s && (gnt_id_q == ID_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end else begin
        stat_d[i] = stat_q[i];
      end
    end
    stat_cnt_d = stat_q[stat_sel];
  end

  // Statistic registers
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        stat_q[i] <= 16'd0;
      end
      stat_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        stat_q[i] <= stat_d[i];
      end
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level
// round-robin burst model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int BL = 4;

  logic clk;
  logic s_rst_n;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .REQ_NUM(R)) bus ();

`ifdef FIFO_WR_ARBITER_STAT_EN
  logic [$clog2(R)-1:0] stat_sel;
  logic [15:0]          stat_cnt;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .REQ_NUM(R), .BURST_LEN(BL)) dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
`ifdef FIFO_WR_ARBITER_STAT_EN
    ,
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: m_gnt = -1 means no grant outstanding
  int m_gnt  = -1;
  int m_beats = 0;
  int m_last = R - 1;
  int pend [R];
  int seq  [R];
  int model_wr_total = 0;
  int dut_wr_total   = 0;
  int phase_dut_wr   = 0;
  logic prev_busy    = 1'b0;
  int gq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic run_cycle(input logic rst, input logic [R-1:0] vmask, input logic full);
    logic [R-1:0]  v;
    logic [DW-1:0] word [R];
    logic [R-1:0]  exp_ready;
    logic          exp_en;
    logic [DW-1:0] exp_data;
    bit            found;
    int            c;
    @(negedge clk);
    s_rst_n = rst;
    for (int i = 0; i < R; i++) begin
      v[i]    = vmask[i] && (pend[i] > 0);
      word[i] = DW'(i * 64 + seq[i] % 64);
      bus.s_data[i*DW +: DW] = word[i];
    end
    bus.s_valid   = v;
    bus.fifo_full = full;
    #1;
    exp_ready = '0;
    exp_en    = 1'b0;
    exp_data  = '0;
    if (rst && m_gnt >= 0) begin
      exp_ready[m_gnt] = !full;
      exp_en           = v[m_gnt] && !full;
      exp_data         = word[m_gnt];
    end
    check("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_en));
    if (exp_en) check("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(exp_data));
    if (rst) begin
      check("busy", 32'(bus.busy), 32'(m_gnt >= 0));
      if (m_gnt >= 0) check("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
      if (bus.busy && !prev_busy) gq.push_back(int'(bus.gnt_id));
    end
    prev_busy = rst ? bus.busy : 1'b0;
    if (bus.fifo_wr_en) begin
      dut_wr_total++;
      phase_dut_wr++;
    end
    // advance the model to the state after the coming rising edge
    if (!rst) begin
      m_gnt = -1; m_beats = 0; m_last = R - 1;
    end else if (m_gnt < 0) begin
      found = 1'b0;
      for (int k = 1; k <= R; k++) begin
        c = (m_last + k) % R;
        if (!found && v[c]) begin
          found = 1'b1; m_gnt = c; m_beats = 0;
        end
      end
    end else if (!v[m_gnt]) begin
      m_last = m_gnt; m_gnt = -1;
    end else if (!full) begin
      m_beats++;
      pend[m_gnt]--;
      seq[m_gnt]++;
      model_wr_total++;
      if (m_beats == BL) begin
        m_last = m_gnt; m_gnt = -1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    int stall;
    int guard;
    logic [R-1:0] rmask;
    for (int i = 0; i < R; i++) begin pend[i] = 0; seq[i] = 0; end
    s_rst_n = 1'b0;
    bus.s_valid = '0; bus.s_data = '0; bus.fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STAT_EN
    stat_sel = 2'd1;
`endif
    do_reset(3);
    run_cycle(1'b1, '0, 1'b0);
    check("reset_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("reset_last_gnt", 32'(dut.last_gnt_q), 32'(R - 1));

    // requester 2 alone with 6 words: 4-beat burst, idle, then 2 beats
    pend[2] = 6; phase_dut_wr = 0;
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 4'b0100, 1'b0);
    check("single_req_writes", 32'(phase_dut_wr), 32'd6);

    // all requesters continuously valid
    do_reset(2);
    for (int i = 0; i < R; i++) pend[i] = 100;
    gq.delete();
    run_cycle(1'b1, 4'b1111, 1'b0);
    phase_dut_wr = 0;
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 4'b1111, 1'b0);
    check("writes_in_20", 32'(phase_dut_wr), 32'd16);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b1111, 1'b0);
    check("grant_seq_len", 32'(gq.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      if (k < gq.size()) check("grant_seq", 32'(gq[k]), 32'(k % R));

    // fifo_full for 3 cycles after beat 2
    do_reset(2);
    for (int i = 0; i < R; i++) pend[i] = 0;
    pend[0] = 4; phase_dut_wr = 0; stall = 0;
    for (int i = 0; i < 12; i++) begin
      if (phase_dut_wr == 2 && stall < 3) begin
        stall++;
        run_cycle(1'b1, 4'b0001, 1'b1);
      end else begin
        run_cycle(1'b1, 4'b0001, 1'b0);
      end
    end
    check("stall_writes", 32'(phase_dut_wr), 32'd4);

    // granted requester 1 drops valid after one beat; requester 2 follows
    do_reset(2);
    for (int i = 0; i < R; i++) pend[i] = 0;
    pend[1] = 5; pend[2] = 5; gq.delete();
    run_cycle(1'b1, 4'b0010, 1'b0);
    run_cycle(1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 4'b0100, 1'b0);
    check("drop_first_gnt", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
    check("drop_next_gnt", 32'(gq.size() > 1 ? gq[1] : -1), 32'd2);

    // reset mid-burst at beat 2, then requester 0 regains priority
    do_reset(2);
    for (int i = 0; i < R; i++) pend[i] = 10;
    run_cycle(1'b1, 4'b1000, 1'b0);
    phase_dut_wr = 0; guard = 0;
    while (phase_dut_wr < 2 && guard < 10) begin
      run_cycle(1'b1, 4'b1111, 1'b0);
      guard++;
    end
    check("midburst_reached", 32'(phase_dut_wr), 32'd2);
    run_cycle(1'b0, 4'b1111, 1'b0);
    gq.delete();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b1111, 1'b0);
    check("post_reset_gnt", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);

`ifdef FIFO_WR_ARBITER_STAT_EN
    do_reset(2);
    for (int i = 0; i < R; i++) pend[i] = 0;
    pend[1] = 10;
    for (int i = 0; i < 18; i++) run_cycle(1'b1, 4'b0010, 1'b0);
    check("stat_cnt", 32'(stat_cnt), 32'd10);
`endif

    // randomized traffic with full stalls, valid drops and occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < R; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 7) == 0) pend[i] = $urandom_range(1, 12);
        rmask[i] = ($urandom_range(0, 5) != 0);
      end
      run_cycle(($urandom_range(0, 99) != 0), rmask, ($urandom_range(0, 3) == 0));
    end
    run_cycle(1'b1, '0, 1'b0);
    check("total_writes", 32'(dut_wr_total), 32'(model_wr_total));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width in bits of one requester data word and of the FIFO write word.
REQ-002 Parameter REQ_NUM, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter BURST_LEN, default 4, maximum beats per grant; legal range 1..16.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 s_rst_n  input  1  synchronous, active-low reset.
REQ-006 s_data  input  REQ_NUM*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_valid  input  REQ_NUM  per-requester data-valid.
REQ-008 s_ready  output  REQ_NUM  per-requester accept; a beat transfers when s_valid[i] and s_ready[i] are both high at a rising edge.
REQ-009 fifo_wr_data  output  DATA_WIDTH  word presented to the FIFO write port.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_full  input  1  FIFO full flag.
REQ-012 gnt_id  output  $clog2(REQ_NUM)  index of the granted requester; valid while busy is high.
REQ-013 busy  output  1  high while in state GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 IDLE: when any s_valid bit is high, the FSM SHALL select the first valid requester searching round-robin from (last_gnt+1) mod REQ_NUM, latch it into gnt_id, clear beat_cnt, and enter GRANT on the next edge; the arbitration latency is 1 cycle.
REQ-016 IDLE: when no s_valid bit is high, the FSM SHALL remain in IDLE.
REQ-017 In IDLE, all s_ready bits and fifo_wr_en SHALL be 0.
REQ-018 GRANT: s_ready[gnt_id] = ~fifo_full, and all other s_ready bits SHALL be 0; combinational from fifo_full.
REQ-019 GRANT: fifo_wr_en = s_valid[gnt_id] & ~fifo_full, and fifo_wr_data = the s_data slice of gnt_id; both combinational.
REQ-020 Each transfer SHALL increment beat_cnt.
REQ-021 A transfer with beat_cnt == BURST_LEN-1 SHALL set last_gnt to gnt_id and return the FSM to IDLE.
REQ-022 In GRANT with s_valid[gnt_id] low, the FSM SHALL set last_gnt to gnt_id and return to IDLE with no transfer.
REQ-023 In GRANT with fifo_full high, the FSM SHALL hold the grant, hold beat_cnt and write nothing; the full-stall does not count toward BURST_LEN.
REQ-024 Fairness: with all requesters continuously valid, grants SHALL cycle 0,1,...,REQ_NUM-1,0; every grant has exactly BURST_LEN beats, with one IDLE cycle between grants.
REQ-025 fifo_wr_en SHALL never be high in a cycle where fifo_full is high.
REQ-026 The block SHALL never drop or duplicate a beat: each transfer produces exactly one fifo_wr_en cycle carrying that beat's data.

Reset
REQ-027 While s_rst_n is low, the FSM SHALL be IDLE, and beat_cnt = 0, last_gnt = REQ_NUM-1 (so requester 0 wins first), gnt_id = 0, busy = 0.
REQ-028 During reset, s_ready = 0 and fifo_wr_en = 0; any burst in progress is abandoned with no further writes.

Configuration
REQ-029 Macro FIFO_WR_ARBITER_STAT_EN: when defined, the block SHALL add input stat_sel ($clog2(REQ_NUM) bits) and output stat_cnt (16 bits).
REQ-030 With FIFO_WR_ARBITER_STAT_EN defined: each requester has a 16-bit beat counter that increments on each transfer, saturates at 0xFFFF and clears on reset; stat_cnt is the registered value of counter[stat_sel], 1 cycle latency.
REQ-031 Without FIFO_WR_ARBITER_STAT_EN: the stat ports and counters are absent, and all other behaviour is identical.

Verification
REQ-032 Reset release, requester 2 only valid with 6 words, fifo_full=0 -> grant 2 after 1 idle cycle; beats 1-4 written, 1 IDLE cycle, then beats 5-6 written; data order preserved.
REQ-033 All 4 requesters continuously valid, fifo_full=0 -> gnt_id sequence 0,1,2,3,0; 4 writes per grant; 16 writes in 20 cycles after the first grant.
REQ-034 fifo_full asserted for 3 cycles mid-burst after beat 2 -> fifo_wr_en=0 and s_ready=0 for those 3 cycles; grant held; beats 3-4 follow; total beats written is 4.
REQ-035 Granted requester drops s_valid after 1 beat -> return to IDLE next edge; the next valid requester in round-robin order is granted.
REQ-036 s_rst_n low mid-burst at beat 2 -> s_ready=0 and fifo_wr_en=0 the next cycle; after release, requester 0 has priority.
REQ-037 With FIFO_WR_ARBITER_STAT_EN defined, 10 beats from requester 1, stat_sel=1 -> stat_cnt=10 one cycle later; counter forced to 0xFFFF stays at 0xFFFF after another beat.
